// File: rtl/serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// serial_compare_ctrl
//
// Bit-serial magnitude/equality comparator controller. Two WIDTH-bit operands
// are walked LSB first through an external 1-bit compare slice. The slice
// folds one bit pair into a running (less, equal) chain. After WIDTH cycles
// the final chain is decoded into a 1-bit result according to the selected
// compare operation.
//
// Signed compares reuse the unsigned slice. On the MSB cycle the two sign
// bits are exchanged before they reach the slice. A negative operand has
// sign bit 1 and a non-negative operand has sign bit 0, so exchanging them
// inverts only the sign ordering. That is exactly the two's-complement
// ordering.
//
// Parameters
//   WIDTH           operand width in bits (2..64)
//
// Ports
//   clk             clock, rising-edge active
//   rst             asynchronous active-high reset
//   start           compare request, sampled only in IDLE
//   src1, src2      operands A and B, captured on an accepted start
//   comp            operation select, captured on an accepted start
//                   0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 GT, 7 LE
//   flush           synchronous abort back to IDLE, no done pulse
//   busy            high while the serial walk is in progress (RUN)
//   done            one-cycle pulse when result is valid
//   result          compare outcome, held until the next completed compare
//   slice_src1      operand A bit presented to the slice
//   slice_src2      operand B bit presented to the slice
//   slice_less      running less-than chain presented to the slice
//   slice_equal     running equal chain presented to the slice
//   slice_is_less   slice less output (combinational from slice_*)
//   slice_is_equal  slice equal output (combinational from slice_*)
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       comp,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             slice_src1,
  output logic             slice_src2,
  output logic             slice_less,
  output logic             slice_equal,
  input  logic             slice_is_less,
  input  logic             slice_is_equal
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_LE  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_comp;
  logic             chain_less;
  logic             chain_equal;

  logic             accept;
  logic             last_bit;
  logic             bit_a;
  logic             bit_b;

  // Decode the final (less, equal) chain into the requested outcome.
  // Signed and unsigned flavours differ only in the MSB swap upstream,
  // so the decode is the same for both.
  function automatic logic comp_outcome(input logic [2:0] op,
                                        input logic       less,
                                        input logic       equal);
    logic res;
    res = 1'b0;
    case (op)
      OP_EQ:   res = equal;
      OP_NE:   res = ~equal;
      OP_LT:   res = less;
      OP_GE:   res = ~less;
      OP_LTU:  res = less;
      OP_GEU:  res = ~less;
      OP_GT:   res = ~less & ~equal;
      OP_LE:   res = less | equal;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Only the two unsigned operations skip the sign-bit exchange.
  function automatic logic is_signed_op(input logic [2:0] op);
    return !((op == OP_LTU) || (op == OP_GEU));
  endfunction

  // flush beats start, so a simultaneous flush/start leaves us in IDLE.
  assign accept   = (state == S_IDLE) && start && !flush;
  assign last_bit = (state == S_RUN) && (idx == LAST_IDX);

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
    end
  end

  // ---- output logic ----
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    bit_a       = op_a[idx];
    bit_b       = op_b[idx];
    slice_src1  = 1'b0;
    slice_src2  = 1'b0;
    slice_less  = 1'b0;
    slice_equal = 1'b0;
    case (state)
      S_RUN: begin
        busy = 1'b1;
        if ((idx == LAST_IDX) && is_signed_op(op_comp)) begin
          slice_src1 = bit_b;
          slice_src2 = bit_a;
        end else begin
          slice_src1 = bit_a;
          slice_src2 = bit_b;
        end
        slice_less  = chain_less;
        slice_equal = chain_equal;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---- control state: bit index, chain, result ----
  // The result register is written on the edge that leaves RUN. It is
  // therefore already valid during the DONE cycle that carries the done
  // pulse. A flush on that same edge suppresses the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      chain_less  <= 1'b0;
      chain_equal <= 1'b1;
      result      <= 1'b0;
    end else begin
      if (accept) begin
        idx         <= '0;
        chain_less  <= 1'b0;
        chain_equal <= 1'b1;
      end else if ((state == S_RUN) && !flush) begin
        chain_less  <= slice_is_less;
        chain_equal <= slice_is_equal;
        idx         <= last_bit ? '0 : idx + IDX_W'(1);
      end
      if (last_bit && !flush) begin
        result <= comp_outcome(op_comp, slice_is_less, slice_is_equal);
      end
    end
  end

  // ---- operand capture ----
  // Operands and comp are captured only on an accepted start. Later
  // changes on the inputs therefore cannot disturb a compare in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a    <= src1;
      op_b    <= src2;
      op_comp <= comp;
    end
  end

endmodule
